// File: rtl/ip_codma_pkg.sv
// Shared state encoding, burst size codes and size decode for the CODMA memory responder.
package ip_codma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      GRANT,
      RDATA,
      WDATA,
      ERROR
   } resp_state_t;

   localparam logic [7:0] SIZE_8B  = 8'd3;
   localparam logic [7:0] SIZE_16B = 8'd8;
   localparam logic [7:0] SIZE_32B = 8'd9;

   // Zero beats flags an illegal size code.
   function automatic logic [3:0] beats_for_size(input logic [7:0] size);
      case (size)
         SIZE_8B:  return 4'd2;
         SIZE_16B: return 4'd4;
         SIZE_32B: return 4'd8;
         default:  return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ip_codma_resp_ram.sv
// Single-port 32-bit word array backing the responder.
// Latency: read data registered, valid the cycle after re_i; write takes effect at the edge.
// Backpressure: none, one access per cycle; contents are never cleared by reset.
module ip_codma_resp_ram #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = 10
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem[addr_i];
      end
   end

endmodule

// File: rtl/ip_codma_mem_responder.sv
// CODMA burst memory responder; CODMA_RESP_ERR_INJECT_EN adds an address-match error injector.
// Latency: grant GRANT_LATENCY+2 cycles after the request cycle; read beats follow grant back to back.
// Backpressure: reads never stall; writes stall on wvalid_i low; requests outside IDLE are ignored.
module ip_codma_mem_responder
   import ip_codma_pkg::*;
#(
   parameter int unsigned MEM_DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0,
   parameter int unsigned GRANT_LATENCY   = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        read_req_i,
   input  logic        write_req_i,
   input  logic [31:0] addr_i,
   input  logic [7:0]  size_i,
   input  logic [31:0] wdata_i,
   input  logic        wvalid_i,
`ifdef CODMA_RESP_ERR_INJECT_EN
   input  logic        err_inj_en_i,
   input  logic [31:0] err_inj_addr_i,
`endif
   output logic        grant_o,
   output logic [31:0] rdata_o,
   output logic        rvalid_o,
   output logic        last_o,
   output logic        error_o,
   output logic        busy_o
);

   localparam int unsigned AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;

   resp_state_t   state_q, state_d;
   logic [7:0]    wait_q, wait_d;
   logic [3:0]    beat_q, beat_d;
   logic [3:0]    nbeats_q, nbeats_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          rd_q, rd_d;

   logic          ram_we, ram_re;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_rdata;

   logic [3:0]    req_beats;
   logic [30:0]   req_diff;
   logic [31:0]   req_idx, req_last;
   logic          req_bad;
   logic          final_beat;

   // Bit 30 of the word difference is the borrow, i.e. addr_i below BASE_ADDR.
   always_comb begin
      req_beats = beats_for_size(size_i);
      req_diff  = {1'b0, addr_i[31:2]} - {1'b0, BASE_ADDR[31:2]};
      req_idx   = {2'b00, req_diff[29:0]};
      req_last  = req_idx + 32'(req_beats) - 32'd1;
      req_bad   = (req_beats == 4'd0) || (addr_i[1:0] != 2'b00) || req_diff[30] ||
                  (req_last >= MEM_DEPTH_WORDS);
`ifdef CODMA_RESP_ERR_INJECT_EN
      req_bad   = req_bad || (err_inj_en_i && (addr_i == err_inj_addr_i));
`endif
   end

   assign final_beat = (beat_q == (nbeats_q - 4'd1));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         wait_q   <= 8'd0;
         beat_q   <= 4'd0;
         nbeats_q <= 4'd0;
         idx_q    <= '0;
         rd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         beat_q   <= beat_d;
         nbeats_q <= nbeats_d;
         idx_q    <= idx_d;
         rd_q     <= rd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      beat_d   = beat_q;
      nbeats_d = nbeats_q;
      idx_d    = idx_q;
      rd_d     = rd_q;
      ram_re   = 1'b0;
      ram_addr = idx_q + AW'(beat_q);

      case (state_q)
         IDLE: begin
            if (read_req_i || write_req_i) begin
               idx_d    = req_idx[AW-1:0];
               nbeats_d = req_beats;
               rd_d     = read_req_i;
               wait_d   = 8'(GRANT_LATENCY);
               state_d  = req_bad ? ERROR : WAIT;
            end
         end
         WAIT: begin
            if (wait_q == 8'd0) begin
               state_d = GRANT;
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         GRANT: begin
            beat_d   = 4'd0;
            ram_addr = idx_q;
            ram_re   = rd_q;
            state_d  = rd_q ? RDATA : WDATA;
         end
         RDATA: begin
            // Prefetch the next word so its data lands with the next beat.
            ram_addr = idx_q + AW'(beat_q) + AW'(1);
            if (final_beat) begin
               state_d = IDLE;
            end else begin
               ram_re = 1'b1;
               beat_d = beat_q + 4'd1;
            end
         end
         WDATA: begin
            if (wvalid_i) begin
               if (final_beat) begin
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + 4'd1;
               end
            end
         end
         ERROR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ram_we   = (state_q == WDATA) && wvalid_i && !reset_i;

   assign grant_o  = (state_q == GRANT);
   assign error_o  = (state_q == ERROR);
   assign busy_o   = (state_q != IDLE);
   assign rvalid_o = (state_q == RDATA);
   assign rdata_o  = rvalid_o ? ram_rdata : 32'd0;
   assign last_o   = final_beat && ((state_q == RDATA) || ((state_q == WDATA) && wvalid_i));

   ip_codma_resp_ram #(
      .DEPTH (MEM_DEPTH_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (wdata_i),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_ip_codma_mem_responder.sv
// Randomized bench for ip_codma_mem_responder against a transaction-level memory model.
module tb_ip_codma_mem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        reset, read_req, write_req, wvalid;
   logic [31:0] addr, wdata;
   logic [7:0]  size;
   logic        grant, rvalid, last, error, busy;
   logic [31:0] rdata;
`ifdef CODMA_RESP_ERR_INJECT_EN
   logic        err_inj_en;
   logic [31:0] err_inj_addr;
`endif

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] ref_mem [DEPTH];

   always #5 clk = ~clk;

   ip_codma_mem_responder #(
      .MEM_DEPTH_WORDS (DEPTH),
      .BASE_ADDR       (32'h0),
      .GRANT_LATENCY   (LAT)
   ) dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .read_req_i     (read_req),
      .write_req_i    (write_req),
      .addr_i         (addr),
      .size_i         (size),
      .wdata_i        (wdata),
      .wvalid_i       (wvalid),
`ifdef CODMA_RESP_ERR_INJECT_EN
      .err_inj_en_i   (err_inj_en),
      .err_inj_addr_i (err_inj_addr),
`endif
      .grant_o        (grant),
      .rdata_o        (rdata),
      .rvalid_o       (rvalid),
      .last_o         (last),
      .error_o        (error),
      .busy_o         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic int beats_of(input logic [7:0] s);
      case (s)
         8'd3:    return 2;
         8'd8:    return 4;
         8'd9:    return 8;
         default: return 0;
      endcase
   endfunction

   function automatic bit legal(input logic [31:0] a, input logic [7:0] s);
      longint idx;
      if (beats_of(s) == 0) return 1'b0;
      if (a[1:0] != 2'b00) return 1'b0;
      idx = longint'(a) / 4;
      if (idx + beats_of(s) > DEPTH) return 1'b0;
`ifdef CODMA_RESP_ERR_INJECT_EN
      if (err_inj_en && a == err_inj_addr) return 1'b0;
`endif
      return 1'b1;
   endfunction

   // Present a request and hold it until grant or error; returns the cycle each was seen.
   task automatic request(input bit rd, input bit wr, input logic [31:0] a, input logic [7:0] s,
                          output int gcyc, output int ecyc);
      gcyc = -1;
      ecyc = -1;
      @(posedge clk); #1;
      read_req = rd; write_req = wr; addr = a; size = s;
      wvalid = wr; wdata = $urandom;
      #1;
      chk("idle_busy", {31'd0, busy}, 0);
      for (int n = 1; n <= 40 && gcyc < 0 && ecyc < 0; n++) begin
         @(posedge clk); #2;
         if (grant) gcyc = n;
         if (error) ecyc = n;
      end
   endtask

   task automatic trailer(input bit ok, input int gcyc, input int ecyc);
      if (ok) begin
         chk("grant_cycle", gcyc, LAT + 2);
         chk("no_error", ecyc, -1);
      end else begin
         chk("error_cycle", ecyc, 1);
         chk("no_grant", gcyc, -1);
      end
      @(posedge clk); #1;
      read_req = 0; write_req = 0; wvalid = 0;
      #1;
      chk("end_busy", {31'd0, busy}, 0);
      chk("end_flags", {28'd0, grant, error, rvalid, last}, 0);
   endtask

   task automatic run_read(input logic [31:0] a, input logic [7:0] s, input bit both);
      int gcyc, ecyc;
      int nb = beats_of(s);
      int idx = int'(a >> 2);
      bit ok = legal(a, s);
      request(1'b1, both, a, s, gcyc, ecyc);
      if (ok && gcyc > 0) begin
         for (int k = 0; k < nb; k++) begin
            @(posedge clk); #1;
            read_req = 0; write_req = 0;
            #1;
            chk("rvalid", {31'd0, rvalid}, 1);
            chk("rdata", rdata, ref_mem[idx + k]);
            chk("rlast", {31'd0, last}, {31'd0, k == nb - 1});
         end
      end
      trailer(ok, gcyc, ecyc);
   endtask

   task automatic run_write(input logic [31:0] a, input logic [7:0] s, input logic [31:0] vpat,
                            input int abort_after, input bit seq, input logic [31:0] dbase);
      int gcyc, ecyc;
      int nb = beats_of(s);
      int idx = int'(a >> 2);
      bit ok = legal(a, s);
      int beat = 0;
      bit aborted = 1'b0;
      bit v;
      request(1'b0, 1'b1, a, s, gcyc, ecyc);
      if (ok && gcyc > 0) begin
         for (int k = 0; k < 64 && beat < nb && !aborted; k++) begin
            @(posedge clk); #1;
            write_req = 0;
            if (abort_after > 0 && beat == abort_after) begin
               wvalid = 0;
               reset  = 1;
               @(posedge clk); #1;
               reset = 0;
               #1;
               chk("rst_outputs", {27'd0, grant, rvalid, last, error, busy}, 0);
               chk("rst_rdata", rdata, 0);
               aborted = 1'b1;
            end else begin
               v      = vpat[k % 32] || (k >= 32);
               wvalid = v;
               wdata  = seq ? dbase + 32'(beat) : $urandom;
               #1;
               chk("wbusy", {31'd0, busy}, 1);
               chk("wlast", {31'd0, last}, {31'd0, v && (beat == nb - 1)});
               if (v) begin
                  ref_mem[idx + beat] = wdata;
                  beat++;
               end
            end
         end
      end
      trailer(ok, gcyc, ecyc);
   endtask

   initial begin
      logic [31:0] a;
      logic [7:0]  s;
      int          sel;
      reset = 1; read_req = 0; write_req = 0; wvalid = 0;
      addr = 0; size = 0; wdata = 0;
`ifdef CODMA_RESP_ERR_INJECT_EN
      err_inj_en = 0; err_inj_addr = 0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {27'd0, grant, rvalid, last, error, busy}, 0);
      chk("reset_rdata", rdata, 0);
      reset = 0;

      // Give every word a known value.
      for (int i = 0; i < DEPTH / 8; i++) run_write(32'(i * 32), 8'd9, 32'hFFFF_FFFF, 0, 1'b0, 0);

      run_write(32'h0, 8'd9, 32'hFFFF_FFFF, 0, 1'b1, 32'h10);
      run_read(32'h0, 8'd9, 1'b0);

      run_write(32'h20, 8'd3, 32'h0000_0005, 0, 1'b1, 32'hA);
      run_read(32'h20, 8'd3, 1'b0);

      run_read(32'h0, 8'd5, 1'b0);
      run_write(32'h2, 8'd3, 32'hFFFF_FFFF, 0, 1'b0, 0);
      run_read(32'hFF8, 8'd9, 1'b0);
      run_write(32'hFF8, 8'd9, 32'hFFFF_FFFF, 0, 1'b0, 0);
      run_read(32'hFF8, 8'd3, 1'b0);
      run_read(32'hFE0, 8'd9, 1'b0);
      run_read(32'h0, 8'd9, 1'b0);

      run_read(32'h40, 8'd9, 1'b1);
      run_read(32'h40, 8'd9, 1'b0);

      run_write(32'h0, 8'd9, 32'hFFFF_FFFF, 3, 1'b0, 0);
      run_read(32'h0, 8'd9, 1'b0);

`ifdef CODMA_RESP_ERR_INJECT_EN
      err_inj_en = 1; err_inj_addr = 32'h100;
      run_read(32'h100, 8'd9, 1'b0);
      run_read(32'h104, 8'd9, 1'b0);
      err_inj_en = 0;
`endif

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 3))
            0:       s = 8'd3;
            1:       s = 8'd8;
            2:       s = 8'd9;
            default: s = 8'($urandom_range(0, 255));
         endcase
         sel = $urandom_range(0, 9);
         if (sel < 7)       a = 32'($urandom_range(0, 1023)) << 2;
         else if (sel == 7) a = (32'($urandom_range(0, 1023)) << 2) | 32'($urandom_range(1, 3));
         else if (sel == 8) a = 32'hFE0 + (32'($urandom_range(0, 7)) << 2);
         else               a = $urandom;
         if ($urandom_range(0, 1) == 1) run_read(a, s, $urandom_range(0, 3) == 0);
         else                           run_write(a, s, $urandom, 0, 1'b0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
